// File: rtl/gate_sweep_checker.sv
// Self-test for the and/or/not gate blocks: sweeps {x,y} through all four
// vectors, checks each response after a settle delay and keeps a result summary.
module gate_sweep_checker #(
    parameter int SETTLE = 2,
    parameter int ERRW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            x_out,
    output logic            y_out,
    input  logic            and_in,
    input  logic            or_in,
    input  logic            not_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [2:0]      err_flags,
    output logic [1:0]      fail_vec,
    output logic            fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    // The settle counter loads SETTLE-1 and counts down to zero, so WAIT spans SETTLE cycles.
    localparam int             WCW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WCW-1:0] WLOAD    = WCW'(SETTLE - 1);
    localparam logic [ERRW-1:0] ERR_MAX = '1;

    state_t          state, state_n;
    logic [1:0]      vec, vec_n;
    logic [WCW-1:0]  wcnt, wcnt_n;
    logic [ERRW-1:0] cnt_q, cnt_n;
    logic [2:0]      flags_q, flags_n;
    logic [1:0]      fvec_q, fvec_n;
    logic            fvalid_q, fvalid_n;
    logic            pass_q, pass_n;
    logic [2:0]      mismatch;

    assign mismatch = {not_in != ~vec[1],
                       or_in  != (vec[1] | vec[0]),
                       and_in != (vec[1] & vec[0])};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            vec      <= 2'd0;
            wcnt     <= '0;
            cnt_q    <= '0;
            flags_q  <= 3'd0;
            fvec_q   <= 2'd0;
            fvalid_q <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state    <= state_n;
            vec      <= vec_n;
            wcnt     <= wcnt_n;
            cnt_q    <= cnt_n;
            flags_q  <= flags_n;
            fvec_q   <= fvec_n;
            fvalid_q <= fvalid_n;
            pass_q   <= pass_n;
        end
    end

    always_comb begin
        state_n  = state;
        vec_n    = vec;
        wcnt_n   = wcnt;
        cnt_n    = cnt_q;
        flags_n  = flags_q;
        fvec_n   = fvec_q;
        fvalid_n = fvalid_q;
        pass_n   = pass_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_WAIT;
                    vec_n    = 2'd0;
                    wcnt_n   = WLOAD;
                    cnt_n    = '0;
                    flags_n  = 3'd0;
                    fvec_n   = 2'd0;
                    fvalid_n = 1'b0;
                    pass_n   = 1'b0;
                end
            end
            S_WAIT: begin
                if (wcnt == '0) begin
                    state_n = S_CHECK;
                end else begin
                    wcnt_n = wcnt - 1'b1;
                end
            end
            S_CHECK: begin
                flags_n = flags_q | mismatch;
                if (|mismatch) begin
                    if (cnt_q != ERR_MAX) begin
                        cnt_n = cnt_q + ERRW'(1);
                    end
                    if (!fvalid_q) begin
                        fvec_n   = vec;
                        fvalid_n = 1'b1;
                    end
                end
                // pass is resolved here so it already reflects the final vector while done is high.
                if (vec == 2'd3) begin
                    state_n = S_DONE;
                    pass_n  = (cnt_q == '0) && !(|mismatch);
                end else begin
                    state_n = S_WAIT;
                    vec_n   = vec + 2'd1;
                    wcnt_n  = WLOAD;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign x_out      = vec[1];
    assign y_out      = vec[0];
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign pass       = pass_q;
    assign err_count  = cnt_q;
    assign err_flags  = flags_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fvalid_q;

endmodule
